pipeline_run_monitor: RTL and testbench
=======================================

// Module: pipeline_run_monitor
// PURPOSE
//  Synthesisable run controller for the MIPS pipeline harness; replaces fixed-time $stop with cycle-accurate termination.
//  Sits beside Pipeline/InstMem/DataMem, snoops the data-memory store bus and instruction address, gates the core via run_en.
//  Detects pass/fail (store to TOHOST_ADDR), timeout and PC hang; optional store-trace FIFO for the bench.
// PARAMETERS
//  ADDR_W       32          width of adr_inst / adr_mem
//  DATA_W       32          width of write_data_mem / exit_code
//  CNT_W        16          width of cycle_cnt / store_cnt (saturating)
//  MAX_CYCLES   58          RUN cycles before timeout (>=1)
//  HANG_LIMIT   8           consecutive RUN cycles with unchanged adr_inst -> hang; 0 disables
//  TOHOST_ADDR  32'h3FC     store address that ends the run
//  TRACE_DEPTH  8           trace FIFO entries, power of two >=2 (TRACE_EN only)
// PORTS
//  clk             in   1               system clock, rising edge
//  rst             in   1               synchronous active-high reset
//  start           in   1               pulse: begin / re-arm a run
//  adr_inst        in   ADDR_W          instruction fetch address from Pipeline
//  adr_mem         in   ADDR_W          data memory address from Pipeline
//  write_data_mem  in   DATA_W          data memory write data
//  mem_write       in   1               data memory write strobe
//  run_en          out  1               core enable; 1 only in RUN
//  done            out  1               run finished; result valid
//  result          out  3               0 none,1 pass,2 fail,3 timeout,4 hang
//  exit_code       out  DATA_W          data of terminating tohost store, else 0
//  cycle_cnt       out  CNT_W           RUN cycles elapsed
//  store_cnt       out  CNT_W           non-tohost stores in RUN
//  trace_valid     out  1               FIFO non-empty
//  trace_addr      out  ADDR_W          FIFO head address
//  trace_data      out  DATA_W          FIFO head data
//  trace_pop       in   1               consume head when trace_valid
//  trace_ovf       out  1               sticky: a store was dropped
// BEHAVIOUR
//  - Reset: state IDLE; run_en,done,trace_valid,trace_ovf=0; result=0; exit_code,cycle_cnt,store_cnt=0; FIFO empty.
//  - States IDLE->RUN on start; RUN->DONE on termination; DONE->RUN on start; any state->IDLE on rst.
//  - Entering RUN clears result,exit_code,counters,hang counter,FIFO,trace_ovf; run_en=1 the cycle after start.
//  - RUN, each cycle: cycle_cnt+=1 saturating at 2^CNT_W-1; hang counter +1 if adr_inst==previous, else 0 (first RUN cycle: 0).
//  - Store (mem_write=1, RUN) to adr_mem==TOHOST_ADDR: data==0 ignored; data==1 -> pass; other -> fail; exit_code=data.
//  - Other RUN stores: store_cnt+=1 saturating; pushed to trace FIFO (TRACE_EN).
//  - Hang when hang counter reaches HANG_LIMIT-1 with equal address this cycle; timeout when cycle_cnt==MAX_CYCLES-1.
//  - Same-cycle priority: pass/fail > hang > timeout.
//  - Latency: terminating event in cycle N -> state DONE, done=1, result valid, run_en=0 at edge ending N (visible N+1).
//  - DONE holds all outputs stable; stores ignored; start in same cycle as termination is ignored.
//  - start while RUN ignored; start in IDLE/DONE with rst=1: rst wins.
// CONFIGURATION
//  PIPELINE_RUN_MONITOR_TRACE_EN defined: FIFO of TRACE_DEPTH {addr,data}, first-word-fall-through head.
//   full & push & !pop -> store dropped, trace_ovf=1 sticky; full & push & pop -> both accepted, stays full.
//   pop when empty ignored; pointers wrap modulo TRACE_DEPTH; FIFO readable in DONE.
//  Undefined: no FIFO storage; trace_valid,trace_addr,trace_data,trace_ovf tied 0; trace_pop ignored.
// TESTING
//  1. rst, start, stores 0x10<-5, 0x3FC<-1 at cycle 4 -> done=1 cycle 5, result=1, store_cnt=1, run_en=0.
//  2. store 0x3FC<-0x7 -> result=2, exit_code=7; store 0x3FC<-0 beforehand -> ignored, run continues.
//  3. adr_inst advancing, no tohost, MAX_CYCLES=58 -> result=3, cycle_cnt=58 after done, run_en 0.
//  4. adr_inst frozen at 0x20, HANG_LIMIT=8 -> result=4 after 8th RUN cycle; tohost pass same cycle -> result=1.
//  5. TRACE_EN, depth 8, 10 stores no pops -> 8 entries in order, trace_ovf=1; pop all -> trace_valid=0.
//  6. rst mid-RUN -> IDLE, all outputs 0 next cycle; start in DONE -> counters cleared, run_en=1.

Source files
------------

// File: rtl/pipeline_run_monitor.sv
// Run controller for the MIPS pipeline harness: gates the core, detects pass/fail/timeout/hang.
// Optional store-trace FIFO enabled by defining PIPELINE_RUN_MONITOR_TRACE_EN.
module pipeline_run_monitor #(
   parameter int                ADDR_W      = 32,
   parameter int                DATA_W      = 32,
   parameter int                CNT_W       = 16,
   parameter int                MAX_CYCLES  = 58,
   parameter int                HANG_LIMIT  = 8,
   parameter logic [ADDR_W-1:0] TOHOST_ADDR = ADDR_W'(32'h3FC),
   parameter int                TRACE_DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] adr_inst,
   input  logic [ADDR_W-1:0] adr_mem,
   input  logic [DATA_W-1:0] write_data_mem,
   input  logic              mem_write,
   output logic              run_en,
   output logic              done,
   output logic [2:0]        result,
   output logic [DATA_W-1:0] exit_code,
   output logic [CNT_W-1:0]  cycle_cnt,
   output logic [CNT_W-1:0]  store_cnt,
   output logic              trace_valid,
   output logic [ADDR_W-1:0] trace_addr,
   output logic [DATA_W-1:0] trace_data,
   input  logic              trace_pop,
   output logic              trace_ovf
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [2:0] RES_NONE    = 3'd0;
   localparam logic [2:0] RES_PASS    = 3'd1;
   localparam logic [2:0] RES_FAIL    = 3'd2;
   localparam logic [2:0] RES_TIMEOUT = 3'd3;
   localparam logic [2:0] RES_HANG    = 3'd4;

   localparam int HANG_W = (HANG_LIMIT > 1) ? $clog2(HANG_LIMIT) : 1;

   state_t              state_q, state_d;
   logic [2:0]          result_q, result_d;
   logic [DATA_W-1:0]   exit_code_q, exit_code_d;
   logic [CNT_W-1:0]    cycle_cnt_q, cycle_cnt_d;
   logic [CNT_W-1:0]    store_cnt_q, store_cnt_d;
   logic [HANG_W-1:0]   hang_cnt_q, hang_cnt_d;
   logic [ADDR_W-1:0]   prev_adr_q, prev_adr_d;
   logic                first_q, first_d;

   logic                is_run;
   logic                enter_run;
   logic                store_evt;
   logic                tohost_evt;
   logic                other_store;
   logic                addr_same;
   logic [HANG_W-1:0]   hang_next;
   logic                hang_evt;
   logic                timeout_evt;

   assign is_run      = (state_q == RUN);
   assign enter_run   = !is_run && start;
   assign store_evt   = is_run && mem_write;
   assign tohost_evt  = store_evt && (adr_mem == TOHOST_ADDR) && (write_data_mem != '0);
   assign other_store = store_evt && (adr_mem != TOHOST_ADDR);
   // The first RUN cycle has no valid previous address, so it always starts a new streak.
   assign addr_same   = !first_q && (adr_inst == prev_adr_q);
   assign timeout_evt = is_run && (cycle_cnt_q == CNT_W'(MAX_CYCLES - 1));

   always_comb begin
      hang_next = '0;
      if (addr_same) begin
         hang_next = (hang_cnt_q == '1) ? hang_cnt_q : hang_cnt_q + HANG_W'(1);
      end
   end

   assign hang_evt = (HANG_LIMIT != 0) && is_run && addr_same &&
                     (hang_next == HANG_W'(HANG_LIMIT - 1));

   always_comb begin
      state_d     = state_q;
      result_d    = result_q;
      exit_code_d = exit_code_q;
      cycle_cnt_d = cycle_cnt_q;
      store_cnt_d = store_cnt_q;
      hang_cnt_d  = hang_cnt_q;
      prev_adr_d  = prev_adr_q;
      first_d     = first_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d     = RUN;
               result_d    = RES_NONE;
               exit_code_d = '0;
               cycle_cnt_d = '0;
               store_cnt_d = '0;
               hang_cnt_d  = '0;
               first_d     = 1'b1;
            end
         end
         RUN: begin
            cycle_cnt_d = (cycle_cnt_q == '1) ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);
            hang_cnt_d  = hang_next;
            prev_adr_d  = adr_inst;
            first_d     = 1'b0;
            if (other_store && (store_cnt_q != '1)) begin
               store_cnt_d = store_cnt_q + CNT_W'(1);
            end
            // A tohost store outranks hang, which outranks timeout.
            if (tohost_evt) begin
               state_d     = DONE;
               result_d    = (write_data_mem == DATA_W'(1)) ? RES_PASS : RES_FAIL;
               exit_code_d = write_data_mem;
            end else if (hang_evt) begin
               state_d  = DONE;
               result_d = RES_HANG;
            end else if (timeout_evt) begin
               state_d  = DONE;
               result_d = RES_TIMEOUT;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         result_q    <= RES_NONE;
         exit_code_q <= '0;
         cycle_cnt_q <= '0;
         store_cnt_q <= '0;
         hang_cnt_q  <= '0;
         prev_adr_q  <= '0;
         first_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         result_q    <= result_d;
         exit_code_q <= exit_code_d;
         cycle_cnt_q <= cycle_cnt_d;
         store_cnt_q <= store_cnt_d;
         hang_cnt_q  <= hang_cnt_d;
         prev_adr_q  <= prev_adr_d;
         first_q     <= first_d;
      end
   end

   assign run_en    = is_run;
   assign done      = (state_q == DONE);
   assign result    = result_q;
   assign exit_code = exit_code_q;
   assign cycle_cnt = cycle_cnt_q;
   assign store_cnt = store_cnt_q;

`ifdef PIPELINE_RUN_MONITOR_TRACE_EN
   localparam int PTR_W = $clog2(TRACE_DEPTH);

   logic [ADDR_W-1:0] fifo_addr_q [TRACE_DEPTH];
   logic [ADDR_W-1:0] fifo_addr_d [TRACE_DEPTH];
   logic [DATA_W-1:0] fifo_data_q [TRACE_DEPTH];
   logic [DATA_W-1:0] fifo_data_d [TRACE_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]    count_q, count_d;
   logic              ovf_q, ovf_d;
   logic              fifo_full;
   logic              pop_ok;
   logic              push_ok;

   assign fifo_full = (count_q == (PTR_W + 1)'(TRACE_DEPTH));
   assign pop_ok    = trace_pop && (count_q != '0);
   // When full, a push is only accepted if the head slot is freed in the same cycle.
   assign push_ok   = other_store && (!fifo_full || pop_ok);

   always_comb begin
      fifo_addr_d = fifo_addr_q;
      fifo_data_d = fifo_data_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      ovf_d       = ovf_q;
      if (enter_run) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
      end else begin
         if (push_ok) begin
            fifo_addr_d[wr_ptr_q] = adr_mem;
            fifo_data_d[wr_ptr_q] = write_data_mem;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
         end else if (other_store) begin
            ovf_d = 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      fifo_addr_q <= fifo_addr_d;
      fifo_data_q <= fifo_data_d;
   end

   assign trace_valid = (count_q != '0);
   assign trace_addr  = fifo_addr_q[rd_ptr_q];
   assign trace_data  = fifo_data_q[rd_ptr_q];
   assign trace_ovf   = ovf_q;
`else
   logic unused_trace;

   assign unused_trace = trace_pop | enter_run | (TRACE_DEPTH == 0);
   assign trace_valid  = 1'b0;
   assign trace_addr   = '0;
   assign trace_data   = '0;
   assign trace_ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_run_monitor.sv
// Directed self-checking bench for pipeline_run_monitor (default parameters).
// Trace FIFO scenarios run when PIPELINE_RUN_MONITOR_TRACE_EN is defined, else tie-offs are checked.
module tb_pipeline_run_monitor;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] adr_inst;
   logic [31:0] adr_mem;
   logic [31:0] write_data_mem;
   logic        mem_write;
   logic        run_en;
   logic        done;
   logic [2:0]  result;
   logic [31:0] exit_code;
   logic [15:0] cycle_cnt;
   logic [15:0] store_cnt;
   logic        trace_valid;
   logic [31:0] trace_addr;
   logic [31:0] trace_data;
   logic        trace_pop;
   logic        trace_ovf;

   int   checks = 0;
   int   errors = 0;
   logic freeze_pc;

   pipeline_run_monitor dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .adr_inst       (adr_inst),
      .adr_mem        (adr_mem),
      .write_data_mem (write_data_mem),
      .mem_write      (mem_write),
      .run_en         (run_en),
      .done           (done),
      .result         (result),
      .exit_code      (exit_code),
      .cycle_cnt      (cycle_cnt),
      .store_cnt      (store_cnt),
      .trace_valid    (trace_valid),
      .trace_addr     (trace_addr),
      .trace_data     (trace_data),
      .trace_pop      (trace_pop),
      .trace_ovf      (trace_ovf)
   );

   always #5 clk = ~clk;

   // Advance one clock; outputs are sampled 1ns after the edge and the PC moves unless frozen.
   task automatic tick();
      @(posedge clk);
      #1;
      if (!freeze_pc) adr_inst = adr_inst + 32'd4;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      mem_write      = 1'b1;
      adr_mem        = a;
      write_data_mem = d;
      tick();
      mem_write      = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; mem_write = 1'b0; trace_pop = 1'b0;
      adr_inst = 32'h0; adr_mem = 32'h0; write_data_mem = 32'h0; freeze_pc = 1'b0;
      tick(); tick();
      checks++;
      if ({run_en, done, result, trace_valid, trace_ovf} !== 7'b0 || exit_code !== 32'h0 ||
          cycle_cnt !== 16'h0 || store_cnt !== 16'h0) begin
         errors++;
         $display("[TB] FAIL reset_state: run_en=%b done=%b result=%0d exit=%0h cyc=%0d st=%0d, required all 0",
                  run_en, done, result, exit_code, cycle_cnt, store_cnt);
      end
      rst = 1'b0;
      tick();
      checks++;
      if ({run_en, done} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL idle_hold: run_en=%b done=%b, required 0 0", run_en, done);
      end
   endtask

   task automatic test_pass();
      start = 1'b1; tick(); start = 1'b0;
      checks++;
      if ({run_en, done} !== 2'b10 || cycle_cnt !== 16'd0) begin
         errors++;
         $display("[TB] FAIL start_latency: run_en=%b done=%b cyc=%0d, required 1 0 0", run_en, done, cycle_cnt);
      end
      tick();
      store(32'h10, 32'h5);
      tick();
      checks++;
      if (cycle_cnt !== 16'd3 || store_cnt !== 16'd1 || done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL pass_midrun: cyc=%0d st=%0d done=%b, required 3 1 0", cycle_cnt, store_cnt, done);
      end
      store(32'h3FC, 32'h1);
      checks++;
      if ({done, run_en} !== 2'b10 || result !== 3'd1 || exit_code !== 32'h1 ||
          cycle_cnt !== 16'd4 || store_cnt !== 16'd1) begin
         errors++;
         $display("[TB] FAIL pass_done: done=%b run_en=%b result=%0d exit=%0h cyc=%0d st=%0d, required 1 0 1 1 4 1",
                  done, run_en, result, exit_code, cycle_cnt, store_cnt);
      end
      store(32'h40, 32'h9);
      tick();
      checks++;
      if (done !== 1'b1 || result !== 3'd1 || cycle_cnt !== 16'd4 || store_cnt !== 16'd1) begin
         errors++;
         $display("[TB] FAIL done_hold: done=%b result=%0d cyc=%0d st=%0d, required 1 1 4 1",
                  done, result, cycle_cnt, store_cnt);
      end
   endtask

   task automatic test_fail();
      start = 1'b1; tick(); start = 1'b0;
      checks++;
      if ({run_en, done} !== 2'b10 || result !== 3'd0 || exit_code !== 32'h0 ||
          cycle_cnt !== 16'd0 || store_cnt !== 16'd0) begin
         errors++;
         $display("[TB] FAIL restart_clear: run_en=%b done=%b result=%0d exit=%0h cyc=%0d st=%0d, required 1 0 0 0 0 0",
                  run_en, done, result, exit_code, cycle_cnt, store_cnt);
      end
      store(32'h3FC, 32'h0);
      checks++;
      if ({run_en, done} !== 2'b10 || result !== 3'd0 || store_cnt !== 16'd0 || cycle_cnt !== 16'd1) begin
         errors++;
         $display("[TB] FAIL tohost_zero: run_en=%b done=%b result=%0d st=%0d cyc=%0d, required 1 0 0 0 1",
                  run_en, done, result, store_cnt, cycle_cnt);
      end
      store(32'h3FC, 32'h7);
      checks++;
      if (done !== 1'b1 || result !== 3'd2 || exit_code !== 32'h7 || cycle_cnt !== 16'd2) begin
         errors++;
         $display("[TB] FAIL fail_done: done=%b result=%0d exit=%0h cyc=%0d, required 1 2 7 2",
                  done, result, exit_code, cycle_cnt);
      end
   endtask

   task automatic test_timeout();
      start = 1'b1; tick(); start = 1'b0;
      repeat (9) tick();
      start = 1'b1; tick(); start = 1'b0;
      checks++;
      if (cycle_cnt !== 16'd10 || run_en !== 1'b1) begin
         errors++;
         $display("[TB] FAIL start_in_run: cyc=%0d run_en=%b, required 10 1", cycle_cnt, run_en);
      end
      repeat (47) tick();
      checks++;
      if (done !== 1'b0 || cycle_cnt !== 16'd57) begin
         errors++;
         $display("[TB] FAIL pre_timeout: done=%b cyc=%0d, required 0 57", done, cycle_cnt);
      end
      start = 1'b1; tick(); start = 1'b0;
      checks++;
      if ({done, run_en} !== 2'b10 || result !== 3'd3 || cycle_cnt !== 16'd58) begin
         errors++;
         $display("[TB] FAIL timeout: done=%b run_en=%b result=%0d cyc=%0d, required 1 0 3 58",
                  done, run_en, result, cycle_cnt);
      end
      tick();
      checks++;
      if ({done, run_en} !== 2'b10 || result !== 3'd3) begin
         errors++;
         $display("[TB] FAIL start_at_term: done=%b run_en=%b result=%0d, required 1 0 3", done, run_en, result);
      end
   endtask

   task automatic test_hang();
      freeze_pc = 1'b1; adr_inst = 32'h20;
      start = 1'b1; tick(); start = 1'b0;
      repeat (7) tick();
      checks++;
      if (done !== 1'b0 || cycle_cnt !== 16'd7) begin
         errors++;
         $display("[TB] FAIL pre_hang: done=%b cyc=%0d, required 0 7", done, cycle_cnt);
      end
      tick();
      checks++;
      if ({done, run_en} !== 2'b10 || result !== 3'd4 || cycle_cnt !== 16'd8) begin
         errors++;
         $display("[TB] FAIL hang: done=%b run_en=%b result=%0d cyc=%0d, required 1 0 4 8",
                  done, run_en, result, cycle_cnt);
      end
   endtask

   task automatic test_hang_streak();
      adr_inst = 32'h20;
      start = 1'b1; tick(); start = 1'b0;
      repeat (6) tick();
      adr_inst = 32'h24;
      repeat (7) tick();
      checks++;
      if (done !== 1'b0 || cycle_cnt !== 16'd13) begin
         errors++;
         $display("[TB] FAIL streak_reset: done=%b cyc=%0d, required 0 13", done, cycle_cnt);
      end
      tick();
      checks++;
      if (done !== 1'b1 || result !== 3'd4 || cycle_cnt !== 16'd14) begin
         errors++;
         $display("[TB] FAIL streak_hang: done=%b result=%0d cyc=%0d, required 1 4 14", done, result, cycle_cnt);
      end
   endtask

   task automatic test_hang_vs_pass();
      adr_inst = 32'h20;
      start = 1'b1; tick(); start = 1'b0;
      repeat (7) tick();
      store(32'h3FC, 32'h1);
      checks++;
      if (done !== 1'b1 || result !== 3'd1 || exit_code !== 32'h1 || cycle_cnt !== 16'd8) begin
         errors++;
         $display("[TB] FAIL pass_over_hang: done=%b result=%0d exit=%0h cyc=%0d, required 1 1 1 8",
                  done, result, exit_code, cycle_cnt);
      end
      freeze_pc = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      start = 1'b1; tick(); start = 1'b0;
      store(32'h10, 32'h3);
      tick();
      rst = 1'b1; tick();
      checks++;
      if ({run_en, done, result, trace_valid, trace_ovf} !== 7'b0 || exit_code !== 32'h0 ||
          cycle_cnt !== 16'h0 || store_cnt !== 16'h0) begin
         errors++;
         $display("[TB] FAIL reset_mid_run: run_en=%b done=%b result=%0d cyc=%0d st=%0d, required all 0",
                  run_en, done, result, cycle_cnt, store_cnt);
      end
      start = 1'b1; tick();
      checks++;
      if (run_en !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rst_over_start: run_en=%b, required 0", run_en);
      end
      rst = 1'b0; start = 1'b0; tick();
      start = 1'b1; tick(); start = 1'b0;
      store(32'h3FC, 32'h1);
      checks++;
      if (done !== 1'b1 || result !== 3'd1 || cycle_cnt !== 16'd1) begin
         errors++;
         $display("[TB] FAIL run_after_reset: done=%b result=%0d cyc=%0d, required 1 1 1", done, result, cycle_cnt);
      end
   endtask

`ifdef PIPELINE_RUN_MONITOR_TRACE_EN
   task automatic test_trace();
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 10; i++) store(32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
      checks++;
      if (store_cnt !== 16'd10 || {trace_valid, trace_ovf} !== 2'b11 ||
          trace_addr !== 32'h100 || trace_data !== 32'hA0) begin
         errors++;
         $display("[TB] FAIL trace_fill: st=%0d valid=%b ovf=%b head=%0h/%0h, required 10 1 1 100/a0",
                  store_cnt, trace_valid, trace_ovf, trace_addr, trace_data);
      end
      store(32'h3FC, 32'h1);
      for (int i = 0; i < 8; i++) begin
         trace_pop = 1'b1;
         checks++;
         if (trace_valid !== 1'b1 || trace_addr !== 32'h100 + 32'(4 * i) || trace_data !== 32'hA0 + 32'(i)) begin
            errors++;
            $display("[TB] FAIL trace_pop%0d: valid=%b head=%0h/%0h, required 1 %0h/%0h",
                     i, trace_valid, trace_addr, trace_data, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
         end
         tick();
      end
      tick();
      trace_pop = 1'b0;
      checks++;
      if ({trace_valid, trace_ovf, done} !== 3'b011) begin
         errors++;
         $display("[TB] FAIL trace_drained: valid=%b ovf=%b done=%b, required 0 1 1", trace_valid, trace_ovf, done);
      end
      start = 1'b1; tick(); start = 1'b0;
      checks++;
      if ({trace_valid, trace_ovf} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL trace_rearm: valid=%b ovf=%b, required 0 0", trace_valid, trace_ovf);
      end
      for (int i = 0; i < 8; i++) store(32'h200 + 32'(4 * i), 32'hB0 + 32'(i));
      trace_pop = 1'b1;
      store(32'h220, 32'hB8);
      for (int i = 1; i <= 8; i++) begin
         checks++;
         if (trace_valid !== 1'b1 || trace_ovf !== 1'b0 || trace_addr !== 32'h200 + 32'(4 * i) ||
             trace_data !== 32'hB0 + 32'(i)) begin
            errors++;
            $display("[TB] FAIL full_push_pop%0d: valid=%b ovf=%b head=%0h/%0h, required 1 0 %0h/%0h",
                     i, trace_valid, trace_ovf, trace_addr, trace_data, 32'h200 + 32'(4 * i), 32'hB0 + 32'(i));
         end
         tick();
      end
      trace_pop = 1'b0;
      checks++;
      if (trace_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL full_drained: valid=%b, required 0", trace_valid);
      end
      store(32'h3FC, 32'h1);
   endtask
`else
   task automatic test_trace();
      start = 1'b1; tick(); start = 1'b0;
      trace_pop = 1'b1;
      for (int i = 0; i < 3; i++) store(32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
      checks++;
      if ({trace_valid, trace_ovf} !== 2'b00 || trace_addr !== 32'h0 || trace_data !== 32'h0 ||
          store_cnt !== 16'd3) begin
         errors++;
         $display("[TB] FAIL trace_tied: valid=%b ovf=%b head=%0h/%0h st=%0d, required 0 0 0/0 3",
                  trace_valid, trace_ovf, trace_addr, trace_data, store_cnt);
      end
      trace_pop = 1'b0;
      store(32'h3FC, 32'h1);
   endtask
`endif

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_pass();
      test_fail();
      test_timeout();
      test_hang();
      test_hang_streak();
      test_hang_vs_pass();
      test_reset_mid_run();
      test_trace();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
